// File: rtl/riscv_hwloop_unit.sv
// ---------------------------------------------------------------------------
// riscv_hwloop_unit
//
// Hardware-loop unit for the ID stage. It holds start, end and iteration
// counter registers for N_LOOPS loop sets. Each set has a small IDLE/ARMED
// state machine. When an armed loop's end address matches the PC in ID, the
// unit selects the lowest-index matching loop (index 0 is the innermost).
// On retirement of that instruction the unit decrements the loop's counter,
// and it either requests a jump back to the loop start or, on the last
// iteration, lets execution fall through and retires the loop.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   hwlp_we_i[2:0]      write enables: [0] start, [1] end, [2] counter
//   hwlp_regid_i        loop set targeted by the write (ignored if >= N_LOOPS)
//   hwlp_start_data_i   start address write data
//   hwlp_end_data_i     end address write data
//   hwlp_cnt_data_i     counter write data (nonzero arms, zero disarms)
//   clear_i             disarm all loops at the next edge, values are kept
//   pc_i                PC of the instruction in ID
//   valid_i             the instruction in ID retires this cycle
//   hwlp_jump_o         combinational jump request to fetch
//   hwlp_target_o       jump target, the start of the selected loop
//   hwlp_sel_o          index of the loop matched this cycle (0 if none)
//   hwlp_exit_o         registered 1-cycle pulse: a loop finished
//   hwlp_active_o       per-loop ARMED flag (state machine debug view)
//   hwlp_start_addr_o   flattened start registers, loop k at [k*ADDR_W +: ADDR_W]
//   hwlp_end_addr_o     flattened end registers
//   hwlp_counter_o      flattened counter registers
//
// Handshake: valid_i qualifies pc_i as a retiring instruction and is the
// only event that advances a loop. hwlp_jump_o is a request with no ready;
// fetch must take it in the same cycle it is raised. hwlp_target_o and
// hwlp_sel_o follow the match regardless of valid_i.
// ---------------------------------------------------------------------------
module riscv_hwloop_unit #(
  parameter int N_LOOPS = 2,
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 32,
  parameter int ID_W    = (N_LOOPS > 1) ? $clog2(N_LOOPS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [2:0]                  hwlp_we_i,
  input  logic [ID_W-1:0]             hwlp_regid_i,
  input  logic [ADDR_W-1:0]           hwlp_start_data_i,
  input  logic [ADDR_W-1:0]           hwlp_end_data_i,
  input  logic [CNT_W-1:0]            hwlp_cnt_data_i,
  input  logic                        clear_i,
  input  logic [ADDR_W-1:0]           pc_i,
  input  logic                        valid_i,
  output logic                        hwlp_jump_o,
  output logic [ADDR_W-1:0]           hwlp_target_o,
  output logic [ID_W-1:0]             hwlp_sel_o,
  output logic                        hwlp_exit_o,
  output logic [N_LOOPS-1:0]          hwlp_active_o,
  output logic [N_LOOPS*ADDR_W-1:0]   hwlp_start_addr_o,
  output logic [N_LOOPS*ADDR_W-1:0]   hwlp_end_addr_o,
  output logic [N_LOOPS*CNT_W-1:0]    hwlp_counter_o
);

  typedef enum logic {
    LOOP_IDLE  = 1'b0,
    LOOP_ARMED = 1'b1
  } loop_state_e;

  loop_state_e       state_q [N_LOOPS];
  loop_state_e       state_d [N_LOOPS];
  logic [ADDR_W-1:0] start_q [N_LOOPS];
  logic [ADDR_W-1:0] start_d [N_LOOPS];
  logic [ADDR_W-1:0] end_q   [N_LOOPS];
  logic [ADDR_W-1:0] end_d   [N_LOOPS];
  logic [CNT_W-1:0]  cnt_q   [N_LOOPS];
  logic [CNT_W-1:0]  cnt_d   [N_LOOPS];
  logic              exit_q;
  logic              exit_d;

  // Write decode
  logic               regid_ok;
  logic [N_LOOPS-1:0] we_start;
  logic [N_LOOPS-1:0] we_end;
  logic [N_LOOPS-1:0] we_cnt;

  // Match and selection
  logic [N_LOOPS-1:0] match;
  logic               any_match;
  logic [ID_W-1:0]    sel;
  logic [CNT_W-1:0]   sel_cnt;
  logic               retire;
  logic               dec_en;
  logic [N_LOOPS-1:0] dec;
  logic [N_LOOPS-1:0] last_iter;

  // -------------------------------------------------------------------------
  // Write decode: each enable bit only touches the addressed set.
  // -------------------------------------------------------------------------
  always_comb begin
    regid_ok = (int'(hwlp_regid_i) < N_LOOPS);
    we_start = '0;
    we_end   = '0;
    we_cnt   = '0;
    for (int k = 0; k < N_LOOPS; k++) begin
      if (regid_ok && (hwlp_regid_i == ID_W'(k))) begin
        we_start[k] = hwlp_we_i[0];
        we_end[k]   = hwlp_we_i[1];
        we_cnt[k]   = hwlp_we_i[2];
      end
    end
  end

  // -------------------------------------------------------------------------
  // End-address match. Scanning from the top down lets the lowest matching
  // index overwrite the selection, so the innermost loop wins.
  // -------------------------------------------------------------------------
  always_comb begin
    match     = '0;
    any_match = 1'b0;
    sel       = '0;
    for (int k = 0; k < N_LOOPS; k++) begin
      match[k] = (state_q[k] == LOOP_ARMED) && (pc_i == end_q[k]);
    end
    for (int k = N_LOOPS - 1; k >= 0; k--) begin
      if (match[k]) begin
        any_match = 1'b1;
        sel       = ID_W'(k);
      end
    end
  end

  assign sel_cnt = cnt_q[sel];
  assign retire  = valid_i && any_match;
  // clear_i cancels the decrement (and therefore the exit pulse) but not the
  // combinational jump decision of the current cycle.
  assign dec_en  = retire && !clear_i;

  // A counter write to the selected loop takes precedence over its decrement.
  always_comb begin
    dec       = '0;
    last_iter = '0;
    for (int k = 0; k < N_LOOPS; k++) begin
      dec[k]       = dec_en && (sel == ID_W'(k)) && !we_cnt[k];
      last_iter[k] = dec[k] && (cnt_q[k] == CNT_W'(1));
    end
  end

  assign exit_d = |last_iter;

  // -------------------------------------------------------------------------
  // Register next-state values
  // -------------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < N_LOOPS; k++) begin
      start_d[k] = we_start[k] ? hwlp_start_data_i : start_q[k];
      end_d[k]   = we_end[k]   ? hwlp_end_data_i   : end_q[k];
      if (we_cnt[k]) begin
        cnt_d[k] = hwlp_cnt_data_i;
      end else if (dec[k]) begin
        cnt_d[k] = cnt_q[k] - CNT_W'(1);
      end else begin
        cnt_d[k] = cnt_q[k];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Loop FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_LOOPS; k++) begin
        state_q[k] <= LOOP_IDLE;
      end
    end else begin
      for (int k = 0; k < N_LOOPS; k++) begin
        state_q[k] <= state_d[k];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Loop FSM: next state. clear_i dominates, then counter writes, then the
  // natural end of the last iteration. Start/end writes never move the FSM.
  // -------------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < N_LOOPS; k++) begin
      state_d[k] = state_q[k];
      if (clear_i) begin
        state_d[k] = LOOP_IDLE;
      end else if (we_cnt[k]) begin
        state_d[k] = (hwlp_cnt_data_i != '0) ? LOOP_ARMED : LOOP_IDLE;
      end else if (last_iter[k]) begin
        state_d[k] = LOOP_IDLE;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Loop FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    hwlp_active_o = '0;
    for (int k = 0; k < N_LOOPS; k++) begin
      hwlp_active_o[k] = (state_q[k] == LOOP_ARMED);
    end
  end

  // -------------------------------------------------------------------------
  // Data registers and exit pulse
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_LOOPS; k++) begin
        start_q[k] <= '0;
        end_q[k]   <= '0;
        cnt_q[k]   <= '0;
      end
      exit_q <= 1'b0;
    end else begin
      for (int k = 0; k < N_LOOPS; k++) begin
        start_q[k] <= start_d[k];
        end_q[k]   <= end_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
      exit_q <= exit_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. A counter of 1 on the selected loop means this retirement is the
  // last iteration, so no jump is requested and execution falls through.
  // -------------------------------------------------------------------------
  assign hwlp_jump_o   = retire && (sel_cnt > CNT_W'(1));
  assign hwlp_target_o = start_q[sel];
  assign hwlp_sel_o    = sel;
  assign hwlp_exit_o   = exit_q;

  always_comb begin
    hwlp_start_addr_o = '0;
    hwlp_end_addr_o   = '0;
    hwlp_counter_o    = '0;
    for (int k = 0; k < N_LOOPS; k++) begin
      hwlp_start_addr_o[k*ADDR_W +: ADDR_W] = start_q[k];
      hwlp_end_addr_o[k*ADDR_W +: ADDR_W]   = end_q[k];
      hwlp_counter_o[k*CNT_W +: CNT_W]      = cnt_q[k];
    end
  end

  // A jump may only be requested for a retiring instruction on an armed loop.
  a_jump_legal: assert property (@(posedge clk) disable iff (!rst_n)
    hwlp_jump_o |-> (valid_i && hwlp_active_o[hwlp_sel_o]));

endmodule
